// File: rtl/main_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm_pkg
// Description : State, opcode, ALUOP and mux-select encodings for the RV32
//               multicycle controller and its ALU decoder.
// Revision    : 1.0
// ============================================================================
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECR    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BEQ      = 4'd10,
        ST_JAL      = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    localparam logic [2:0] c_ALUOP_ADD     = 3'b000;
    localparam logic [2:0] c_ALUOP_SUB     = 3'b001;
    localparam logic [2:0] c_ALUOP_SPECIAL = 3'b111;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;

    localparam logic [1:0] c_SRCB_RS2   = 2'b00;
    localparam logic [1:0] c_SRCB_IMM   = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    // Opcode dispatch out of DECODE; unsupported opcodes land in TRAP.
    function automatic state_t decode_next(input logic [6:0] i_opcode);
        state_t w_st;
        case (i_opcode)
            c_OP_LW, c_OP_SW: w_st = ST_MEMADR;
            c_OP_R:           w_st = ST_EXECR;
            c_OP_I:           w_st = ST_EXECI;
            c_OP_BEQ:         w_st = ST_BEQ;
            c_OP_JAL:         w_st = ST_JAL;
            default:          w_st = ST_TRAP;
        endcase
        return w_st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm_if
// Description : Controller <-> datapath/memory bundle: opcode, flags,
//               handshake, strobes and mux selects.
// Revision    : 1.0
// ============================================================================
interface main_control_fsm_if #(
    parameter int ALUOP_W = 3
);
    logic [6:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               PC_Write;
    logic               IR_Write;
    logic               Mem_Read;
    logic               Mem_Write;
    logic               Reg_Write;
    logic               Adr_Src;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         Result_Src;
    logic [ALUOP_W-1:0] ALUOP;

    modport master (
        input  opcode, zero, mem_ready,
        output PC_Write, IR_Write, Mem_Read, Mem_Write, Reg_Write, Adr_Src,
               ALUSrcA, ALUSrcB, Result_Src, ALUOP
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PC_Write, IR_Write, Mem_Read, Mem_Write, Reg_Write, Adr_Src,
               ALUSrcA, ALUSrcB, Result_Src, ALUOP
    );
endinterface
`default_nettype wire

// File: rtl/main_control_fsm_instret_counter.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm_instret_counter
// Description : Retired-instruction counter, wraps modulo 2^CNT_W.
// Revision    : 1.0
// ============================================================================
module main_control_fsm_instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm
// Description : Multicycle RV32 main controller (lw, sw, R, I, beq, jal).
// Revision    : 1.0
// ============================================================================
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    main_control_fsm_if.master bus,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_retire;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_srca;
    logic [1:0] w_srcb;
    logic [1:0] w_res_src;
    logic [2:0] w_aluop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == ST_TRAP);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_adr_src   = 1'b0;
        w_srca      = c_SRCA_PC;
        w_srcb      = c_SRCB_RS2;
        w_res_src   = c_RES_ALUOUT;
        w_aluop     = c_ALUOP_ADD;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_read = 1'b1;
                w_srcb     = c_SRCB_FOUR;
                w_res_src  = c_RES_ALURESULT;
                w_pc_write = bus.mem_ready;
                w_ir_write = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_srca = c_SRCA_OLDPC;
                w_srcb = c_SRCB_IMM;
                w_next = decode_next(bus.opcode);
            end
            ST_MEMADR: begin
                w_srca = c_SRCA_RS1;
                w_srcb = c_SRCB_IMM;
                w_next = (bus.opcode == c_OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                w_mem_read = 1'b1;
                w_adr_src  = 1'b1;
                if (bus.mem_ready) begin
                    w_next = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                w_res_src   = c_RES_MEMDATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_MEMWRITE: begin
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_EXECR: begin
                w_srca  = c_SRCA_RS1;
                w_srcb  = c_SRCB_RS2;
                w_aluop = c_ALUOP_SPECIAL;
                w_next  = ST_ALUWB;
            end
            ST_EXECI: begin
                w_srca  = c_SRCA_RS1;
                w_srcb  = c_SRCB_IMM;
                w_aluop = c_ALUOP_SPECIAL;
                w_next  = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_BEQ: begin
                w_srca     = c_SRCA_RS1;
                w_srcb     = c_SRCB_RS2;
                w_aluop    = c_ALUOP_SUB;
                w_pc_write = bus.zero;
                w_retire   = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_JAL: begin
                w_srca      = c_SRCA_OLDPC;
                w_srcb      = c_SRCB_FOUR;
                w_pc_write  = 1'b1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_TRAP: begin
                w_next = ST_TRAP;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.PC_Write   = w_pc_write;
    assign bus.IR_Write   = w_ir_write;
    assign bus.Mem_Read   = w_mem_read;
    assign bus.Mem_Write  = w_mem_write;
    assign bus.Reg_Write  = w_reg_write;
    assign bus.Adr_Src    = w_adr_src;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.Result_Src = w_res_src;
    assign bus.ALUOP      = ALUOP_W'(w_aluop);
    assign illegal        = r_illegal;

    main_control_fsm_instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_retire),
        .o_count (instret)
    );

endmodule
`default_nettype wire
